// File: rtl/note_sequencer.sv
// Note-table sequencer: plays {half_period, duration} entries in order, one FETCH
// cycle between notes, durations counted in prescaled ticks of TICK_DIV clocks.
module note_sequencer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [15:0]                wr_data,
   input  logic [$clog2(DEPTH)-1:0]   last_idx,
   input  logic                       loop,
   input  logic                       start,
   input  logic                       stop,
   output logic [7:0]                 half_period,
   output logic                       note_en,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   note_idx
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] last_q, last_d;
   logic          loop_q, loop_d;
   logic [7:0]    hp_q, hp_d;
   logic [7:0]    dur_q, dur_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          done_q, done_d;
   logic [15:0]   note_mem [DEPTH];
   logic [15:0]   entry;
   logic          tick;

   assign entry = note_mem[idx_q];
   assign tick  = (pre_q == PreMax);

   // Table is not reset; contents are only meaningful after being written.
   always_ff @(posedge clk) begin
      if (wr_en && (state_q == StIdle)) begin
         note_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         hp_q    <= '0;
         dur_q   <= '0;
         pre_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         hp_q    <= hp_d;
         dur_q   <= dur_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      loop_d  = loop_q;
      hp_d    = hp_q;
      dur_d   = dur_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               last_d  = last_idx;
               loop_d  = loop;
               idx_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (stop) begin
               state_d = StIdle;
               hp_d    = '0;
               dur_d   = '0;
               pre_d   = '0;
            end else if (entry[7:0] == 8'd0) begin
               // Zero duration marks end of song, even when looping.
               state_d = StIdle;
               hp_d    = '0;
               dur_d   = '0;
               pre_d   = '0;
               done_d  = 1'b1;
            end else begin
               hp_d    = entry[15:8];
               dur_d   = entry[7:0];
               pre_d   = '0;
               state_d = StPlay;
            end
         end
         StPlay: begin
            if (stop) begin
               state_d = StIdle;
               hp_d    = '0;
               dur_d   = '0;
               pre_d   = '0;
            end else begin
               pre_d = tick ? '0 : pre_q + 1'b1;
               if (tick) begin
                  dur_d = dur_q - 8'd1;
                  if (dur_q == 8'd1) begin
                     if (idx_q != last_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                     end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = StFetch;
                     end else begin
                        state_d = StIdle;
                        hp_d    = '0;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign half_period = hp_q;
   assign note_en     = (state_q == StPlay) && (hp_q != 8'd0);
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign note_idx    = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed songs plus randomized tables,
// each checked cycle by cycle against a song-level reference model.
module tb_note_sequencer;

   localparam int DEPTH = 8;
   localparam int TICK  = 4;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic [AW-1:0] last_idx;
   logic          loop;
   logic          start;
   logic          stop;
   logic [7:0]    half_period;
   logic          note_en;
   logic          busy;
   logic          done;
   logic [AW-1:0] note_idx;

   logic [15:0]   model [DEPTH];
   int            n_checks = 0;
   int            n_pass   = 0;

   note_sequencer #(
      .DEPTH    (DEPTH),
      .TICK_DIV (TICK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .last_idx    (last_idx),
      .loop        (loop),
      .start       (start),
      .stop        (stop),
      .half_period (half_period),
      .note_en     (note_en),
      .busy        (busy),
      .done        (done),
      .note_idx    (note_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic quiet();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
      step();
      wr_en = 1'b0;
      model[a] = d;
   endtask

   task automatic check_idle(input string tag, input logic exp_done);
      check({tag, "_done"}, done, exp_done);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_hp"}, half_period, 0);
      check({tag, "_en"}, note_en, 0);
   endtask

   // Plays a song from the model table; loop songs are stopped in FETCH after max_notes.
   task automatic run_song(input int last, input bit lp, input int max_notes, input bit disturb);
      int          idx;
      int          notes;
      bit          fin;
      logic [15:0] e;
      idx = 0; notes = 0; fin = 0;
      last_idx = last[AW-1:0]; loop = lp; start = 1'b1;
      step();
      start = 1'b0;
      while (!fin) begin
         check("fetch_busy", busy, 1);
         check("fetch_en", note_en, 0);
         check("fetch_idx", note_idx, idx);
         check("fetch_done", done, 0);
         e = model[idx];
         if (lp && notes >= max_notes) begin
            quiet(); stop = 1'b1;
            step();
            stop = 1'b0;
            check_idle("stop_fetch", 0);
            fin = 1;
         end else begin
            step();
            if (e[7:0] == 8'd0) begin
               quiet();
               check_idle("end_marker", 1);
               check("end_marker_idx", note_idx, idx);
               fin = 1;
            end else begin
               for (int c = 0; c < e[7:0] * TICK; c++) begin
                  check("play_hp", half_period, e[15:8]);
                  check("play_en", note_en, e[15:8] != 8'd0);
                  check("play_busy", busy, 1);
                  check("play_done", done, 0);
                  check("play_idx", note_idx, idx);
                  if (disturb) begin
                     start = 1'($urandom_range(0, 1));
                     wr_en = 1'($urandom_range(0, 1));
                     wr_addr = AW'($urandom);
                     wr_data = 16'($urandom);
                     last_idx = AW'($urandom);
                     loop = 1'($urandom_range(0, 1));
                  end
                  step();
               end
               notes++;
               if (idx == last && !lp) begin
                  quiet();
                  check_idle("song_end", 1);
                  check("song_end_idx", note_idx, idx);
                  fin = 1;
               end else begin
                  idx = (idx == last) ? 0 : idx + 1;
               end
               if (notes > 64) begin
                  check("note_budget", notes, 64);
                  quiet(); stop = 1'b1; step(); stop = 1'b0;
                  fin = 1;
               end
            end
         end
      end
      quiet();
      step();
      check("after_done", done, 0);
      check("after_busy", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0101;
      step();
      step();
      check_idle("reset", 0);
      check("reset_idx", note_idx, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < DEPTH; i++) wr(i, 16'h0101);

      // Two-note song, then a rest entry.
      wr(0, {8'd3, 8'd2});
      wr(1, {8'd5, 8'd1});
      run_song(1, 1'b0, 0, 1'b0);
      wr(0, {8'd0, 8'd3});
      wr(1, {8'd9, 8'd1});
      run_song(1, 1'b0, 0, 1'b0);

      // Looping song stopped in FETCH, then an end marker mid-table.
      wr(0, {8'd4, 8'd1});
      wr(1, {8'd6, 8'd2});
      run_song(1, 1'b1, 5, 1'b0);
      wr(0, {8'd7, 8'd1});
      wr(1, {8'h11, 8'd0});
      wr(2, {8'd2, 8'd1});
      wr(3, {8'd3, 8'd1});
      run_song(3, 1'b0, 0, 1'b0);

      // Full table; writes and starts during playback must be ignored.
      for (int i = 0; i < DEPTH; i++) wr(i, {8'(i + 1), 8'd1});
      run_song(DEPTH - 1, 1'b0, 0, 1'b1);
      run_song(DEPTH - 1, 1'b0, 0, 1'b0);

      // start and stop together in IDLE.
      start = 1'b1; stop = 1'b1;
      step();
      check("start_stop_busy", busy, 0);
      step();
      check("start_stop_busy2", busy, 0);
      quiet();

      // Stop mid-PLAY.
      wr(0, {8'd8, 8'd3});
      last_idx = '0; loop = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      check("mid_play_en", note_en, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_idle("stop_play", 0);

      // Asynchronous reset mid-note.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle("async_reset", 0);
      check("async_reset_idx", note_idx, 0);
      step();
      rst_n = 1'b1;
      step();
      check_idle("post_reset", 0);
      step();
      check("no_resume", busy, 0);

      // Randomized tables and song parameters.
      for (int r = 0; r < 10; r++) begin
         for (int a = 0; a < DEPTH; a++) begin
            logic [7:0] hp;
            logic [7:0] du;
            hp = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            du = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            wr(a, {hp, du});
         end
         run_song($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 10), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
